mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential Booth multiplier among `N_REQ` requesters in the control loop. It accepts operand pairs over a valid/ready handshake and drives the multiplier's `arm`, `a1` and `a2` inputs. It waits for `fin`, then returns the product to the owning requester with a one-hot completion pulse. A watchdog aborts any job whose `fin` never arrives.

---
 rtl/mul_arbiter.sv | 134 +++++++++++++
 tb/tb_mul_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one sequential Booth multiplier among N_REQ requesters.
// Holds operands while the multiplier runs, returns the product or a timeout to the owner.
module mul_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_SIZ      = 2,
  parameter int unsigned A1_LEN      = 32,
  parameter int unsigned A2_LEN      = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_SIZ      = 8
) (
  input  logic                       clk,
  input  logic                       rst_L,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*A1_LEN-1:0]    req_a1,
  input  logic [N_REQ*A2_LEN-1:0]    req_a2,
  output logic [N_REQ-1:0]           req_ready,
  output logic [A1_LEN+A2_LEN-1:0]   res_data,
  output logic [N_REQ-1:0]           res_valid,
  output logic                       res_err,
  output logic                       busy,
  output logic                       mul_arm,
  output logic [A1_LEN-1:0]          mul_a1,
  output logic [A2_LEN-1:0]          mul_a2,
  input  logic [A1_LEN+A2_LEN-1:0]   mul_outn,
  input  logic                       mul_fin
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                     state_q;
  logic [ID_SIZ-1:0]          ptr_q, id_q;
  logic [TO_SIZ-1:0]          to_q;
  logic [A1_LEN+A2_LEN-1:0]   res_data_q;
  logic [N_REQ-1:0]           res_valid_q;
  logic                       res_err_q, busy_q, arm_q;
  logic [A1_LEN-1:0]          a1_q;
  logic [A2_LEN-1:0]          a2_q;

  logic                       gnt_vld;
  logic [ID_SIZ-1:0]          gnt_id, ptr_nxt;
  logic [A1_LEN-1:0]          gnt_a1;
  logic [A2_LEN-1:0]          gnt_a2;

  // Two passes: indices at/above ptr first, then the wrapped ones below ptr.
  always_comb begin
    req_ready = '0;
    gnt_vld   = 1'b0;
    gnt_id    = '0;
    gnt_a1    = '0;
    gnt_a2    = '0;
    if (state_q == StIdle) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!gnt_vld && (j >= 32'(ptr_q)) && req_valid[j]) begin
          gnt_vld      = 1'b1;
          req_ready[j] = 1'b1;
          gnt_id       = ID_SIZ'(j);
          gnt_a1       = req_a1[j*A1_LEN +: A1_LEN];
          gnt_a2       = req_a2[j*A2_LEN +: A2_LEN];
        end
      end
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!gnt_vld && (j < 32'(ptr_q)) && req_valid[j]) begin
          gnt_vld      = 1'b1;
          req_ready[j] = 1'b1;
          gnt_id       = ID_SIZ'(j);
          gnt_a1       = req_a1[j*A1_LEN +: A1_LEN];
          gnt_a2       = req_a2[j*A2_LEN +: A2_LEN];
        end
      end
    end
  end

  assign ptr_nxt = (gnt_id == ID_SIZ'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      to_q        <= '0;
      res_data_q  <= '0;
      res_valid_q <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      arm_q       <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
    end else begin
      res_valid_q <= '0;
      res_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // mul_fin may linger one cycle after a job; it is deliberately ignored here.
          if (gnt_vld) begin
            a1_q    <= gnt_a1;
            a2_q    <= gnt_a2;
            id_q    <= gnt_id;
            arm_q   <= 1'b1;
            busy_q  <= 1'b1;
            to_q    <= '0;
            ptr_q   <= ptr_nxt;
            state_q <= StRun;
          end
        end
        StRun: begin
          to_q <= to_q + 1'b1;
          if (mul_fin) begin
            res_data_q        <= mul_outn;
            res_valid_q[id_q] <= 1'b1;
            arm_q             <= 1'b0;
            busy_q            <= 1'b0;
            state_q           <= StIdle;
          end else if (to_q == TO_SIZ'(TIMEOUT_CYC)) begin
            res_data_q        <= '0;
            res_valid_q[id_q] <= 1'b1;
            res_err_q         <= 1'b1;
            arm_q             <= 1'b0;
            busy_q            <= 1'b0;
            state_q           <= StIdle;
          end
        end
      endcase
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;
  assign mul_arm   = arm_q;
  assign mul_a1    = a1_q;
  assign mul_a2    = a2_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural Booth-timing multiplier model.
module tb_mul_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AL = 32;

  logic              clk = 1'b0;
  logic              rst_L;
  logic [NR-1:0]     req_valid;
  logic [NR*AL-1:0]  req_a1, req_a2;
  logic [NR-1:0]     req_ready;
  logic [2*AL-1:0]   res_data;
  logic [NR-1:0]     res_valid;
  logic              res_err, busy, mul_arm;
  logic [AL-1:0]     mul_a1, mul_a2;
  logic [2*AL-1:0]   mul_outn;
  logic              mul_fin;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit fin_dis  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mul_arbiter #(
    .N_REQ(NR), .ID_SIZ(2), .A1_LEN(AL), .A2_LEN(AL), .TIMEOUT_CYC(255), .TO_SIZ(8)
  ) dut (
    .clk(clk), .rst_L(rst_L), .req_valid(req_valid), .req_a1(req_a1), .req_a2(req_a2),
    .req_ready(req_ready), .res_data(res_data), .res_valid(res_valid), .res_err(res_err),
    .busy(busy), .mul_arm(mul_arm), .mul_a1(mul_a1), .mul_a2(mul_a2),
    .mul_outn(mul_outn), .mul_fin(mul_fin)
  );

  // Multiplier model: loads at E1, raises fin at E(AL+2), clears on arm low.
  int   mcnt;
  logic mfin;
  logic [2*AL-1:0] sa, sb;
  always @(posedge clk) begin
    if (!mul_arm) begin
      mcnt <= 0;
      mfin <= 1'b0;
    end else begin
      if (mcnt <= int'(AL) + 1) mcnt <= mcnt + 1;
      mfin <= !fin_dis && ((mcnt == int'(AL) + 1) || mfin);
    end
  end
  assign sa       = {{AL{mul_a1[AL-1]}}, mul_a1};
  assign sb       = {{AL{mul_a2[AL-1]}}, mul_a2};
  assign mul_outn = sa * sb;
  assign mul_fin  = mfin;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input int id, input logic [31:0] a1, input logic [31:0] a2);
    req_a1[id*AL +: AL] = a1;
    req_a2[id*AL +: AL] = a2;
    req_valid[id]       = 1'b1;
  endtask

  task automatic accept(input string tag, input logic [3:0] exp_ready, input bit hold,
                        output int acc_cyc);
    #1;
    check_eq({tag, "_grant"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = req_valid & ~exp_ready;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_arm"}, 64'(mul_arm), 64'd1);
  endtask

  task automatic wait_res(input string tag, input logic [3:0] exp_v, input logic [63:0] exp_d,
                          input bit exp_e, input int exp_lat, input logic [3:0] drop_mask);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 10) req_valid = req_valid & ~drop_mask;
      if (res_valid != '0) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_eq({tag, "_vld"}, 64'(res_valid), 64'(exp_v));
    check_eq({tag, "_data"}, res_data, exp_d);
    check_eq({tag, "_err"}, 64'(res_err), 64'(exp_e));
    check_eq({tag, "_arm0"}, 64'(mul_arm), 64'd0);
    check_eq({tag, "_busy0"}, 64'(busy), 64'd0);
  endtask

  logic [63:0] rr_exp [4];
  int ac, prev;

  initial begin
    rr_exp[0] = 64'd30;
    rr_exp[1] = 64'hFFFF_FFFF_FFFF_FFEE;
    rr_exp[2] = 64'hFFFF_FFFF_FFF5_51A0;
    rr_exp[3] = 64'h0000_0000_FFFF_FFFE;
    prev = 0;
    rst_L = 1'b0;
    req_valid = '0;
    req_a1 = '0;
    req_a2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_arm", 64'(mul_arm), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_vld", 64'(res_valid), 64'd0);
    check_eq("rst_err", 64'(res_err), 64'd0);
    check_eq("rst_data", res_data, 64'd0);
    check_eq("rst_a1", 64'(mul_a1), 64'd0);
    check_eq("rst_a2", 64'(mul_a2), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    rst_L = 1'b1;

    // Single job on requester 2: -3 * 7.
    start(2, 32'hFFFF_FFFD, 32'd7);
    accept("t1", 4'b0100, 1'b0, ac);
    check_eq("t1_mul_a1", 64'(mul_a1), 64'h0000_0000_FFFF_FFFD);
    check_eq("t1_mul_a2", 64'(mul_a2), 64'd7);
    wait_res("t1", 4'b0100, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 35, 4'b0000);
    @(posedge clk);
    #1;
    check_eq("t1_pulse", 64'(res_valid), 64'd0);
    check_eq("t1_hold", res_data, 64'hFFFF_FFFF_FFFF_FFEB);

    // All four valid from reset, held: order 0,1,2,3,0 and 36-cycle spacing.
    rst_L = 1'b0;
    #1;
    rst_L = 1'b1;
    start(0, 32'd5, 32'd6);
    start(1, 32'hFFFF_FFFE, 32'd9);
    start(2, 32'd100000, 32'hFFFF_FFF9);
    start(3, 32'h7FFF_FFFF, 32'd2);
    for (int j = 0; j < 5; j++) begin
      accept("rr", 4'(1 << (j % 4)), 1'b1, ac);
      if (j > 0) check_eq("rr_spacing", 64'(ac - prev), 64'd36);
      prev = ac;
      wait_res("rr", 4'(1 << (j % 4)), rr_exp[j % 4], 1'b0, 35, 4'b0000);
    end
    req_valid = '0;

    // Corner operands.
    start(1, 32'h8000_0000, 32'h8000_0000);
    accept("c1", 4'b0010, 1'b0, ac);
    wait_res("c1", 4'b0010, 64'h4000_0000_0000_0000, 1'b0, 35, 4'b0000);
    start(1, 32'd0, 32'hFFFF_FFFF);
    accept("c2", 4'b0010, 1'b0, ac);
    wait_res("c2", 4'b0010, 64'd0, 1'b0, 35, 4'b0000);
    start(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    accept("c3", 4'b0010, 1'b0, ac);
    wait_res("c3", 4'b0010, 64'd1, 1'b0, 35, 4'b0000);

    // Watchdog abort with fin held low, then normal service.
    fin_dis = 1'b1;
    start(3, 32'd5, 32'd5);
    accept("to", 4'b1000, 1'b0, ac);
    wait_res("to", 4'b1000, 64'd0, 1'b1, 256, 4'b0000);
    fin_dis = 1'b0;
    @(posedge clk);
    #1;
    check_eq("to_errclr", 64'(res_err), 64'd0);
    start(3, 32'd6, 32'd7);
    accept("after_to", 4'b1000, 1'b0, ac);
    wait_res("after_to", 4'b1000, 64'd42, 1'b0, 35, 4'b0000);

    // Requester 1 drops while 3 runs; ptr is 2 after serving 1.
    start(1, 32'd2, 32'd3);
    accept("pre", 4'b0010, 1'b0, ac);
    wait_res("pre", 4'b0010, 64'd6, 1'b0, 35, 4'b0000);
    start(1, 32'd4, 32'd4);
    start(3, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    accept("drop", 4'b1000, 1'b0, ac);
    wait_res("drop", 4'b1000, 64'd25, 1'b0, 35, 4'b0010);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("drop_ready", 64'(req_ready), 64'd0);
      check_eq("drop_vld", 64'(res_valid), 64'd0);
    end

    // Reset mid-RUN on requester 2's job; afterwards requester 0 wins over 3.
    start(2, 32'd11, 32'd13);
    accept("mr", 4'b0100, 1'b0, ac);
    repeat (14) @(posedge clk);
    #2;
    rst_L = 1'b0;
    #1;
    check_eq("mr_arm", 64'(mul_arm), 64'd0);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_vld", 64'(res_valid), 64'd0);
    start(0, 32'd9, 32'd9);
    start(3, 32'd1, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("mr_vld2", 64'(res_valid), 64'd0);
    rst_L = 1'b1;
    #1;
    check_eq("mr_prio", 64'(req_ready), 64'b0001);
    req_valid = 4'b0001;
    accept("mr_next", 4'b0001, 1'b0, ac);
    wait_res("mr_next", 4'b0001, 64'd81, 1'b0, 35, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
